// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NPORTS byte producers, each with a
// one-byte holding buffer. Watches tx_ready to sequence each byte and flag a dead transmitter.
module uart_tx_arbiter_slot (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_i,
  input  logic       clear_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic [7:0] data_o
);
  logic       full_q;
  logic [7:0] data_q;

  // load only happens while empty and clear only while full, so they never collide
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
endmodule

module uart_tx_arbiter #(
  parameter int NPORTS       = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NPORTS-1:0]     in_valid,
  input  logic [8*NPORTS-1:0]   in_data,
  output logic [NPORTS-1:0]     in_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic [NPORTS-1:0]     grant,
  output logic [NPORTS-1:0]     sent,
  output logic                  err,
  output logic                  busy
);
  localparam int PW = $clog2(NPORTS);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            ptr_q, ptr_d, win;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tx_start_q, tx_start_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic [NPORTS-1:0]        grant_q, grant_d;
  logic [NPORTS-1:0]        sent_q, sent_d;
  logic                     err_q, err_d;
  logic [NPORTS-1:0]        full, load, issue_oh;
  logic [NPORTS-1:0][7:0]   in_bytes, buf_data;
  logic                     any_full;

  assign in_bytes = in_data;
  assign load     = in_valid & ~full;

  for (genvar i = 0; i < NPORTS; i++) begin : g_slot
    uart_tx_arbiter_slot u_slot (
      .clk    (clk),
      .rstn   (rstn),
      .load_i (load[i]),
      .clear_i(issue_oh[i]),
      .data_i (in_bytes[i]),
      .full_o (full[i]),
      .data_o (buf_data[i])
    );
  end

  // Search descends so the port nearest ptr+1 is written last and wins.
  always_comb begin
    int idx;
    idx      = 0;
    any_full = 1'b0;
    win      = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NPORTS;
      if (full[idx]) begin
        any_full = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    sent_d     = '0;
    err_d      = 1'b0;
    issue_oh   = '0;
    unique case (state_q)
      IDLE: if (tx_ready && any_full) begin
        issue_oh[win] = 1'b1;
        grant_d       = '0;
        grant_d[win]  = 1'b1;
        tx_data_d     = buf_data[win];
        tx_start_d    = 1'b1;
        ptr_d         = win;
        state_d       = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // transmitter never acknowledged: drop the byte, no retry
          err_d   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: if (tx_ready) begin
        sent_d  = grant_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(NPORTS - 1);
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      sent_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = ~full;
  assign busy     = (state_q != IDLE);
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign sent     = sent_q;
  assign err      = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table for the single-byte
// case plus hand-written sequences for ordering, timeout, ready-gating and reset.
module tb_uart_tx_arbiter;
  localparam int NP   = 4;
  localparam int BT   = 4;
  localparam int LINE = 3;  // cycles the uart model stays not-ready per byte

  logic            clk = 1'b0;
  logic            rstn;
  logic [NP-1:0]   in_valid;
  logic [8*NP-1:0] in_data;
  logic [NP-1:0]   in_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [NP-1:0]   grant, sent;
  logic            err, busy;

  uart_tx_arbiter #(.NPORTS(NP), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant(grant), .sent(sent), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // uart_tx model: drops ready the cycle after a start strobe, for LINE cycles.
  // It ignores rstn so a byte already on the line finishes.
  int   line_cnt = 0;
  logic stuck    = 1'b0;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    if (tx_start && !stuck) line_cnt <= LINE;
    else if (line_cnt > 0)  line_cnt <= line_cnt - 1;
  end
  assign tx_ready = (line_cnt == 0) && !hold_low;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] issq[$];
  int          issc[$];
  logic [3:0]  sentq[$];
  int          sentc[$];
  always @(negedge clk) if (rstn) begin
    if (tx_start) begin issq.push_back({grant, tx_data}); issc.push_back(cyc); end
    if (|sent)    begin sentq.push_back(sent); sentc.push_back(cyc); end
  end

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_q();
    issq.delete(); issc.delete(); sentq.delete(); sentc.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = '0; in_data = '0; stuck = 1'b0; hold_low = 1'b0;
    tick(); tick();
    for (int i = 0; i < 20 && line_cnt != 0; i++) tick();
    rstn = 1'b1;
    clear_q();
    tick();
  endtask

  task automatic wait_issues(input int n, input string name);
    for (int i = 0; i < 400 && issq.size() < n; i++) tick();
    chk({name, "_issue_cnt"}, issq.size(), n);
  endtask

  task automatic wait_sents(input int n, input string name);
    for (int i = 0; i < 400 && sentq.size() < n; i++) tick();
    chk({name, "_sent_cnt"}, sentq.size(), n);
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  ir;
    logic        st;
    logic [7:0]  td;
    logic [3:0]  g;
    logic [3:0]  s;
    logic        e;
    logic        b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int st_c, err_c;
    logic [3:0] g_at_err, s_at_err;

    // single byte from port 1; each row = inputs before an edge, outputs after it
    vecs[0] = '{4'b0010, 32'h0000_4100, 4'b1101, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{4'b0000, 32'h0000_4100, 4'b1111, 1'b1, 8'h41, 4'b0010, 4'b0000, 1'b0, 1'b1};
    vecs[2] = '{4'b0000, 32'h0000_4100, 4'b1111, 1'b0, 8'h41, 4'b0010, 4'b0000, 1'b0, 1'b1};
    vecs[3] = '{4'b0000, 32'h0000_4100, 4'b1111, 1'b0, 8'h41, 4'b0010, 4'b0000, 1'b0, 1'b1};
    vecs[4] = '{4'b0000, 32'h0000_4100, 4'b1111, 1'b0, 8'h41, 4'b0010, 4'b0000, 1'b0, 1'b1};
    vecs[5] = '{4'b0000, 32'h0000_4100, 4'b1111, 1'b0, 8'h41, 4'b0010, 4'b0000, 1'b0, 1'b1};
    vecs[6] = '{4'b0000, 32'h0000_4100, 4'b1111, 1'b0, 8'h41, 4'b0000, 4'b0010, 1'b0, 1'b0};
    vecs[7] = '{4'b0000, 32'h0000_4100, 4'b1111, 1'b0, 8'h41, 4'b0000, 4'b0000, 1'b0, 1'b0};

    rstn = 1'b0; in_valid = '0; in_data = '0;
    tick();
    chk("reset_state", {in_ready, tx_start, tx_data, grant, sent, err, busy},
        {4'b1111, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0});
    do_reset();

    for (int r = 0; r < 8; r++) begin
      in_valid = vecs[r].v;
      in_data  = vecs[r].d;
      tick();
      chk($sformatf("vec%0d", r), {in_ready, tx_start, tx_data, grant, sent, err, busy},
          {vecs[r].ir, vecs[r].st, vecs[r].td, vecs[r].g, vecs[r].s, vecs[r].e, vecs[r].b});
    end

    // all four ports at once: order 0..3, no idle gap between sent and next start
    do_reset();
    in_valid = 4'b1111; in_data = 32'hA3A2_A1A0;
    tick();
    in_valid = '0;
    chk("all4_in_ready", in_ready, 4'b0000);
    wait_sents(4, "all4");
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << k;
      chk($sformatf("all4_issue%0d", k), issq[k], {oh, 8'hA0 + 8'(k)});
      chk($sformatf("all4_sent%0d", k), sentq[k], oh);
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("all4_gap%0d", k), issc[k+1], sentc[k] + 1);

    // round robin with refill and wrap from port 3 to port 0
    do_reset();
    in_valid = 4'b0101; in_data = 32'h0020_0010;
    tick();
    in_valid = '0;
    wait_issues(2, "rr_first");
    in_valid = 4'b1101; in_data = 32'h3021_0011;
    tick();
    in_valid = '0;
    wait_sents(5, "rr");
    chk("rr_issue0", issq[0], {4'b0001, 8'h10});
    chk("rr_issue1", issq[1], {4'b0100, 8'h20});
    chk("rr_issue2", issq[2], {4'b1000, 8'h30});
    chk("rr_issue3", issq[3], {4'b0001, 8'h11});
    chk("rr_issue4", issq[4], {4'b0100, 8'h21});

    // transmitter never drops ready: err, byte dropped, next byte still served
    do_reset();
    stuck = 1'b1;
    in_valid = 4'b1010; in_data = 32'h6600_5500;
    tick();
    in_valid = '0;
    st_c = -1; err_c = -1; g_at_err = 'x; s_at_err = 'x;
    for (int i = 0; i < 60 && err_c < 0; i++) begin
      if (tx_start && st_c < 0) st_c = cyc;
      if (err) begin err_c = cyc; g_at_err = grant; s_at_err = sent; end
      if (err_c < 0) tick();
    end
    stuck = 1'b0;
    // err appears BT cycles after the ISSUE cycle ends
    chk("to_err_delay", err_c - st_c, BT + 1);
    chk("to_grant_at_err", g_at_err, 4'b0000);
    chk("to_sent_at_err", s_at_err, 4'b0000);
    tick();
    chk("to_err_pulse", err, 1'b0);
    wait_sents(1, "to");
    chk("to_sent_owner", sentq[0], 4'b1000);
    chk("to_issue0", issq[0], {4'b0010, 8'h55});
    chk("to_issue1", issq[1], {4'b1000, 8'h66});

    // ready held low when the buffer fills: no start until it returns
    do_reset();
    hold_low = 1'b1;
    in_valid = 4'b0100; in_data = 32'h0077_0000;
    tick();
    in_valid = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("hold_no_start", {issq.size(), busy, in_ready}, {32'd0, 1'b0, 4'b1011});
    hold_low = 1'b0;
    tick();
    chk("hold_start", {tx_start, tx_data, grant}, {1'b1, 8'h77, 4'b0100});
    wait_sents(1, "hold");

    // reset in WAIT_DONE with two bytes buffered
    do_reset();
    in_valid = 4'b0001; in_data = 32'h0000_0001;
    tick();
    in_valid = '0;
    wait_issues(1, "rst");
    in_valid = 4'b0110; in_data = 32'h0003_0200;
    tick();
    in_valid = '0;
    tick();
    chk("rst_pre_busy", {busy, in_ready}, {1'b1, 4'b1001});
    rstn = 1'b0;
    #1;
    chk("rst_async", {grant, tx_start, in_ready, busy, sent},
        {4'b0000, 1'b0, 4'b1111, 1'b0, 4'b0000});
    tick();
    rstn = 1'b1;
    clear_q();
    for (int i = 0; i < 12; i++) tick();
    chk("rst_quiet", {sentq.size(), issq.size(), in_ready}, {32'd0, 32'd0, 4'b1111});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
